sva_result_collector: RTL and testbench

- Downstream of the per-property SVA checker FSM; consumes its succ / fail / lazy_succ pulses in the sys_clk domain.
- Aggregates them into saturating counters and a sticky verdict state machine.
- Keeps a small FIFO log of the gclk window indices in which failures occurred, drained by a valid/ready reader (testbench dumper or debug bus).

---
 rtl/sva_result_collector_if.sv | 21 ++
 rtl/sva_result_collector.sv | 161 ++++++++++++++++
 tb/tb_sva_result_collector.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/sva_result_collector_if.sv
// Fail-log reader bus: valid/ready handshake carrying the logged window index.
// master = collector (drives log_valid/log_window), slave = reader (drives log_ready).
interface sva_result_collector_if #(
    parameter int W = 16
);
    logic         log_valid;
    logic         log_ready;
    logic [W-1:0] log_window;

    modport master (
        output log_valid,
        output log_window,
        input  log_ready
    );

    modport slave (
        input  log_valid,
        input  log_window,
        output log_ready
    );
endinterface

// File: rtl/sva_result_collector.sv
// Collects SVA checker pulses into saturating counters, a sticky verdict and a fail-window log.
// Ports: sys_clk/sys_rst/clr, window_tick, succ/fail/lazy_succ in; counters, verdict,
// first-fail capture, log_overflow out; fail-log reader on the log interface (master side).
module sva_result_collector #(
    parameter int CNT_WIDTH    = 16,
    parameter int LOG_DEPTH    = 4,
    parameter bit STOP_ON_FAIL = 1'b0
) (
    input  logic                 sys_clk,
    input  logic                 sys_rst,
    input  logic                 clr,
    input  logic                 window_tick,
    input  logic                 succ,
    input  logic                 fail,
    input  logic                 lazy_succ,
    output logic [CNT_WIDTH-1:0] succ_cnt,
    output logic [CNT_WIDTH-1:0] fail_cnt,
    output logic [CNT_WIDTH-1:0] lazy_cnt,
    output logic [CNT_WIDTH-1:0] window_cnt,
    output logic [1:0]           verdict,
    output logic                 first_fail_valid,
    output logic [CNT_WIDTH-1:0] first_fail_window,
    output logic                 log_overflow,
    sva_result_collector_if.master log
);

    localparam int AW = $clog2(LOG_DEPTH);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;
    localparam logic [AW:0] DEPTH_C = (AW+1)'(LOG_DEPTH);

    typedef enum logic [1:0] {
        V_IDLE = 2'd0,
        V_RUN  = 2'd1,
        V_PASS = 2'd2,
        V_FAIL = 2'd3
    } verdict_e;

    verdict_e state_q, state_d;

    logic                 rst;
    logic                 live;
    logic [CNT_WIDTH-1:0] succ_q, fail_q, lazy_q, window_q;
    logic                 ffv_q;
    logic [CNT_WIDTH-1:0] ffw_q;
    logic                 seen_q;
    logic                 ovf_q;

    logic [CNT_WIDTH-1:0] mem_q [LOG_DEPTH];
    logic [AW-1:0]        wr_ptr_q, rd_ptr_q;
    logic [AW:0]          count_q;
    logic                 empty, full;
    logic                 push_req, push, pop, drop;

    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
        return (v == CNT_MAX) ? v : v + 1'b1;
    endfunction

    assign rst = sys_rst | clr;

    // Once frozen only clr/reset leave FAIL, so the freeze lasts until then.
    assign live = !(STOP_ON_FAIL && state_q == V_FAIL);

    // ---------------- event and window counters ----------------
    always_ff @(posedge sys_clk) begin
        if (rst) begin
            succ_q   <= '0;
            fail_q   <= '0;
            lazy_q   <= '0;
            window_q <= '0;
        end else if (live) begin
            if (succ)        succ_q   <= sat_inc(succ_q);
            if (fail)        fail_q   <= sat_inc(fail_q);
            if (lazy_succ)   lazy_q   <= sat_inc(lazy_q);
            if (window_tick) window_q <= sat_inc(window_q);
        end
    end

    // ---------------- verdict FSM ----------------
    always_ff @(posedge sys_clk) begin
        if (rst) state_q <= V_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            V_IDLE: begin
                if (fail)                   state_d = V_FAIL;
                else if (succ || lazy_succ) state_d = V_PASS;
                else if (window_tick)       state_d = V_RUN;
            end
            V_RUN: begin
                if (fail)                   state_d = V_FAIL;
                else if (succ || lazy_succ) state_d = V_PASS;
            end
            V_PASS: begin
                if (fail) state_d = V_FAIL;
            end
            V_FAIL: state_d = V_FAIL;
        endcase
    end

    // ---------------- first failure capture ----------------
    always_ff @(posedge sys_clk) begin
        if (rst) begin
            ffv_q <= 1'b0;
            ffw_q <= '0;
        end else if (fail && !ffv_q) begin
            ffv_q <= 1'b1;
            ffw_q <= window_q;
        end
    end

    // ---------------- fail log ----------------
    assign empty    = (count_q == '0);
    assign full     = (count_q == DEPTH_C);
    assign push_req = fail && live && !seen_q;
    assign pop      = !empty && log.log_ready;
    assign push     = push_req && (!full || pop);
    assign drop     = push_req && full && !pop;

    // A fail on the tick cycle is charged to the closing window,
    // so the new window always starts with a clean seen flag.
    always_ff @(posedge sys_clk) begin
        if (rst)              seen_q <= 1'b0;
        else if (window_tick) seen_q <= 1'b0;
        else if (push_req)    seen_q <= 1'b1;
    end

    always_ff @(posedge sys_clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            if (push && !pop)      count_q <= count_q + 1'b1;
            else if (pop && !push) count_q <= count_q - 1'b1;
            if (drop) ovf_q <= 1'b1;
        end
    end

    always_ff @(posedge sys_clk) begin
        if (push) mem_q[wr_ptr_q] <= window_q;
    end

    // ---------------- outputs ----------------
    assign succ_cnt          = succ_q;
    assign fail_cnt          = fail_q;
    assign lazy_cnt          = lazy_q;
    assign window_cnt        = window_q;
    assign verdict           = state_q;
    assign first_fail_valid  = ffv_q;
    assign first_fail_window = ffw_q;
    assign log_overflow      = ovf_q;
    assign log.log_valid     = !empty;
    assign log.log_window    = empty ? '0 : mem_q[rd_ptr_q];

endmodule

// File: tb/tb_sva_result_collector.sv
// Self-checking bench: two collectors (16-bit free-running, 4-bit stop-on-fail)
// driven in parallel, compared each cycle against a queue-based reference model.
module tb_sva_result_collector;

    logic sys_clk = 1'b0;
    logic sys_rst = 1'b1;
    logic clr = 1'b0;
    logic window_tick = 1'b0;
    logic succ = 1'b0;
    logic fail = 1'b0;
    logic lazy_succ = 1'b0;
    logic log_ready = 1'b0;

    logic [15:0] a_succ, a_fail, a_lazy, a_win, a_ffw;
    logic [1:0]  a_verd;
    logic        a_ffv, a_ovf;
    logic [3:0]  b_succ, b_fail, b_lazy, b_win, b_ffw;
    logic [1:0]  b_verd;
    logic        b_ffv, b_ovf;

    sva_result_collector_if #(.W(16)) la ();
    sva_result_collector_if #(.W(4))  lb ();

    assign la.log_ready = log_ready;
    assign lb.log_ready = log_ready;

    always #5 sys_clk = ~sys_clk;

    sva_result_collector #(.CNT_WIDTH(16), .LOG_DEPTH(4), .STOP_ON_FAIL(1'b0)) dut_a (
        .sys_clk(sys_clk), .sys_rst(sys_rst), .clr(clr),
        .window_tick(window_tick), .succ(succ), .fail(fail), .lazy_succ(lazy_succ),
        .succ_cnt(a_succ), .fail_cnt(a_fail), .lazy_cnt(a_lazy), .window_cnt(a_win),
        .verdict(a_verd), .first_fail_valid(a_ffv), .first_fail_window(a_ffw),
        .log_overflow(a_ovf), .log(la)
    );

    sva_result_collector #(.CNT_WIDTH(4), .LOG_DEPTH(4), .STOP_ON_FAIL(1'b1)) dut_b (
        .sys_clk(sys_clk), .sys_rst(sys_rst), .clr(clr),
        .window_tick(window_tick), .succ(succ), .fail(fail), .lazy_succ(lazy_succ),
        .succ_cnt(b_succ), .fail_cnt(b_fail), .lazy_cnt(b_lazy), .window_cnt(b_win),
        .verdict(b_verd), .first_fail_valid(b_ffv), .first_fail_window(b_ffw),
        .log_overflow(b_ovf), .log(lb)
    );

    int n_total = 0;
    int n_pass = 0;
    int n_fail = 0;

    // reference model state, index 0 = dut_a, 1 = dut_b
    int m_max[2] = '{65535, 15};
    bit m_stop[2] = '{1'b0, 1'b1};
    int m_succ[2], m_failc[2], m_lazy[2], m_win[2], m_verd[2], m_ffw[2];
    bit m_ffv[2], m_ovf[2], m_logged[2];
    int mq[2][$];

    function automatic int sat(int v, int mx);
        return (v >= mx) ? mx : v + 1;
    endfunction

    task automatic model_step(int k);
        int cur;
        bit frz, pop, preq;
        if (sys_rst || clr) begin
            m_succ[k] = 0; m_failc[k] = 0; m_lazy[k] = 0; m_win[k] = 0;
            m_verd[k] = 0; m_ffv[k] = 0; m_ffw[k] = 0; m_ovf[k] = 0;
            m_logged[k] = 0;
            mq[k].delete();
            return;
        end
        frz  = m_stop[k] && (m_verd[k] == 3);
        cur  = m_win[k];
        pop  = (mq[k].size() > 0) && log_ready;
        preq = fail && !frz && !m_logged[k];
        if (!frz) begin
            if (succ)        m_succ[k]  = sat(m_succ[k], m_max[k]);
            if (fail)        m_failc[k] = sat(m_failc[k], m_max[k]);
            if (lazy_succ)   m_lazy[k]  = sat(m_lazy[k], m_max[k]);
            if (window_tick) m_win[k]   = sat(m_win[k], m_max[k]);
        end
        if (fail) m_verd[k] = 3;
        else if (m_verd[k] < 2 && (succ || lazy_succ)) m_verd[k] = 2;
        else if (m_verd[k] == 0 && window_tick) m_verd[k] = 1;
        if (fail && !m_ffv[k]) begin
            m_ffv[k] = 1;
            m_ffw[k] = cur;
        end
        if (pop) void'(mq[k].pop_front());
        if (preq) begin
            if (mq[k].size() < 4) mq[k].push_back(cur);
            else m_ovf[k] = 1;
        end
        if (window_tick) m_logged[k] = 0;
        else if (preq) m_logged[k] = 1;
    endtask

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        int hw;
        chk("A.succ_cnt", 32'(a_succ), m_succ[0]);
        chk("A.fail_cnt", 32'(a_fail), m_failc[0]);
        chk("A.lazy_cnt", 32'(a_lazy), m_lazy[0]);
        chk("A.window_cnt", 32'(a_win), m_win[0]);
        chk("A.verdict", 32'(a_verd), m_verd[0]);
        chk("A.ff_valid", 32'(a_ffv), 32'(m_ffv[0]));
        chk("A.ff_window", 32'(a_ffw), m_ffw[0]);
        chk("A.overflow", 32'(a_ovf), 32'(m_ovf[0]));
        chk("A.log_valid", 32'(la.log_valid), 32'(mq[0].size() > 0));
        hw = (mq[0].size() > 0) ? mq[0][0] : 0;
        chk("A.log_window", 32'(la.log_window), hw);
        chk("B.succ_cnt", 32'(b_succ), m_succ[1]);
        chk("B.fail_cnt", 32'(b_fail), m_failc[1]);
        chk("B.lazy_cnt", 32'(b_lazy), m_lazy[1]);
        chk("B.window_cnt", 32'(b_win), m_win[1]);
        chk("B.verdict", 32'(b_verd), m_verd[1]);
        chk("B.ff_valid", 32'(b_ffv), 32'(m_ffv[1]));
        chk("B.ff_window", 32'(b_ffw), m_ffw[1]);
        chk("B.overflow", 32'(b_ovf), 32'(m_ovf[1]));
        chk("B.log_valid", 32'(lb.log_valid), 32'(mq[1].size() > 0));
        hw = (mq[1].size() > 0) ? mq[1][0] : 0;
        chk("B.log_window", 32'(lb.log_window), hw);
    endtask

    task automatic step(input bit t, input bit s, input bit f, input bit l,
                        input bit r, input bit c, input bit x = 1'b0);
        window_tick = t;
        succ        = s;
        fail        = f;
        lazy_succ   = l;
        log_ready   = r;
        clr         = c;
        sys_rst     = x;
        @(posedge sys_clk);
        model_step(0);
        model_step(1);
        #1;
        check_all();
    endtask

    initial begin
        // reset
        step(0, 0, 0, 0, 0, 0, 1);
        step(1, 1, 1, 1, 1, 0, 1);
        chk("rst.verdict", 32'(a_verd), 0);
        chk("rst.log_valid", 32'(la.log_valid), 0);

        // three windows, one succ each
        for (int i = 0; i < 3; i++) begin
            step(1, 0, 0, 0, 0, 0);
            step(0, 1, 0, 0, 0, 0);
        end
        chk("tp1.window", 32'(a_win), 3);
        chk("tp1.succ", 32'(a_succ), 3);
        chk("tp1.verdict", 32'(a_verd), 2);
        chk("tp1.log_valid", 32'(la.log_valid), 0);

        // two fails inside window 2, reader stalled
        step(0, 0, 0, 0, 0, 1);
        step(1, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0);
        step(0, 0, 1, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0);
        step(0, 0, 1, 0, 0, 0);
        chk("tp2.fail_cnt", 32'(a_fail), 2);
        chk("tp2.log_window", 32'(la.log_window), 2);
        chk("tp2.ff_window", 32'(a_ffw), 2);
        chk("tp2.verdict", 32'(a_verd), 3);
        step(0, 1, 0, 0, 0, 0);
        chk("tp2.sticky", 32'(a_verd), 3);

        // fail coincident with tick at window 5, then fail in window 6
        step(1, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0);
        step(1, 0, 1, 0, 0, 0);
        chk("tp3.window", 32'(a_win), 6);
        step(0, 0, 1, 0, 0, 0);
        for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 1, 0);

        // overflow with a stalled reader, then drain
        step(0, 0, 0, 0, 0, 1);
        for (int i = 0; i < 5; i++) begin
            step(1, 0, 0, 0, 0, 0);
            step(0, 0, 1, 0, 0, 0);
        end
        chk("tp4.overflow", 32'(a_ovf), 1);
        chk("tp4.head", 32'(la.log_window), 1);
        for (int i = 0; i < 5; i++) step(0, 0, 0, 0, 1, 0);
        chk("tp4.drained", 32'(la.log_valid), 0);

        // saturation, then clr with a coincident fail
        step(0, 0, 0, 0, 0, 1);
        for (int i = 0; i < 20; i++) step(0, 1, 0, 0, 0, 0);
        chk("tp5.b_sat", 32'(b_succ), 15);
        chk("tp5.a_succ", 32'(a_succ), 20);
        step(0, 0, 1, 0, 0, 1);
        chk("tp5.clr_succ", 32'(b_succ), 0);
        chk("tp5.clr_verdict", 32'(b_verd), 0);

        // stop-on-fail freeze
        step(1, 0, 0, 0, 0, 0);
        step(0, 0, 1, 0, 0, 0);
        for (int i = 0; i < 3; i++) step(0, 1, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0);
        chk("tp6.succ", 32'(b_succ), 0);
        chk("tp6.window", 32'(b_win), 1);
        chk("tp6.fail", 32'(b_fail), 1);
        chk("tp6.verdict", 32'(b_verd), 3);

        // randomized traffic
        for (int i = 0; i < 800; i++) begin
            step($urandom_range(3) == 0,
                 $urandom_range(2) == 0,
                 $urandom_range(9) == 0,
                 $urandom_range(5) == 0,
                 $urandom_range(1) == 0,
                 $urandom_range(49) == 0,
                 $urandom_range(299) == 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
